// File: rtl/vend_change_machine.sv
// Coin vending controller with a configurable price and dime-first change payout.
// Credit is held in nickel units and shrinks to zero as change coins are returned.
module vend_change_machine #(
  parameter  int PRICE_NICKELS = 3,
  parameter  int CNT_W         = 16,
  localparam int CW            = $clog2(PRICE_NICKELS + 5)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             nickel,
  input  logic             dime,
  input  logic             quarter,
  input  logic             cancel,
  output logic             dispense,
  output logic             ret_nickel,
  output logic             ret_dime,
  output logic             coin_reject,
  output logic             busy,
  output logic [CW-1:0]    credit,
  output logic [CNT_W-1:0] sales
);

  localparam int W1 = CW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    VEND,
    PAYOUT
  } state_t;

  state_t      state;
  logic [1:0]  n_coins;
  logic [W1-1:0] coin_val;
  logic [W1-1:0] sum;
  logic        accepting;
  logic        legal;
  logic        illegal;

  always_comb begin
    n_coins   = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
    coin_val  = '0;
    if (quarter)
      coin_val = W1'(5);
    else if (dime)
      coin_val = W1'(2);
    else if (nickel)
      coin_val = W1'(1);
    sum       = {1'b0, credit} + coin_val;
    accepting = (state == IDLE) || (state == ACCUM);
    legal     = accepting && (n_coins == 2'd1);
    // Multi-coin edges and coins during a sale are bounced, not credited
    illegal   = (n_coins >= 2'd2) || (!accepting && (n_coins != 2'd0));
  end

  assign dispense   = (state == VEND);
  assign ret_dime   = (state == PAYOUT) && (credit >= CW'(2));
  assign ret_nickel = (state == PAYOUT) && (credit < CW'(2));
  assign busy       = (state == VEND) || (state == PAYOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      credit      <= '0;
      sales       <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= illegal;
      unique case (state)
        IDLE, ACCUM: begin
          if (legal) begin
            credit <= CW'(sum);
            if (cancel)
              state <= PAYOUT;
            else if (sum >= W1'(PRICE_NICKELS))
              state <= VEND;
            else
              state <= ACCUM;
          end else if (!illegal && cancel && state == ACCUM) begin
            state <= PAYOUT;
          end
        end
        VEND: begin
          credit <= credit - CW'(PRICE_NICKELS);
          if (sales != '1)
            sales <= sales + 1'b1;
          if (credit == CW'(PRICE_NICKELS))
            state <= IDLE;
          else
            state <= PAYOUT;
        end
        PAYOUT: begin
          if (credit >= CW'(2))
            credit <= credit - CW'(2);
          else
            credit <= credit - CW'(1);
          if (credit <= CW'(2))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_machine.sv
// Scoreboard bench for vend_change_machine at PRICE=3, plus a CNT_W=2 copy
// sharing the same stimulus to exercise sales saturation.
module tb_vend_change_machine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic nickel = 1'b0;
  logic dime = 1'b0;
  logic quarter = 1'b0;
  logic cancel = 1'b0;

  logic        dispense, ret_nickel, ret_dime, coin_reject, busy;
  logic [2:0]  credit;
  logic [15:0] sales;

  logic        dispense2, ret_nickel2, ret_dime2, coin_reject2, busy2;
  logic [2:0]  credit2;
  logic [1:0]  sales2;

  vend_change_machine #(.PRICE_NICKELS(3), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .nickel(nickel), .dime(dime), .quarter(quarter), .cancel(cancel),
    .dispense(dispense), .ret_nickel(ret_nickel), .ret_dime(ret_dime),
    .coin_reject(coin_reject), .busy(busy), .credit(credit), .sales(sales)
  );

  vend_change_machine #(.PRICE_NICKELS(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .nickel(nickel), .dime(dime), .quarter(quarter), .cancel(cancel),
    .dispense(dispense2), .ret_nickel(ret_nickel2), .ret_dime(ret_dime2),
    .coin_reject(coin_reject2), .busy(busy2), .credit(credit2), .sales(sales2)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] D  = 4'b1000;
  localparam logic [3:0] RD = 4'b0100;
  localparam logic [3:0] RN = 4'b0010;
  localparam logic [3:0] RJ = 4'b0001;

  typedef struct packed {
    logic [3:0] ev;
    logic [7:0] cr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int exp_sales = 0;

  task automatic push(input logic [3:0] ev, input int cr);
    q.push_back({ev, 8'(cr)});
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Output-event monitor: every pulse cycle must match the next queued entry
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t e;
    if (reset_n) begin
      ev = {dispense, ret_dime, ret_nickel, coin_reject};
      if (ev != 4'b0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got=%b credit=%0d", ev, credit);
        end else begin
          e = q.pop_front();
          if (e.ev !== ev || e.cr !== 8'(credit)) begin
            bad++;
            $display("FAIL event got=%b/%0d want=%b/%0d",
                     ev, credit, e.ev, e.cr);
          end
        end
      end
    end
  end

  task automatic pulse(input logic n, input logic d,
                       input logic qt, input logic c);
    nickel = n; dime = d; quarter = qt; cancel = c;
    @(posedge clk);
    #1;
    nickel = 0; dime = 0; quarter = 0; cancel = 0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || q.size() != 0) && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_drain"}, q.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_credit"}, int'(credit), 0);
    chk({name, "_sales"}, int'(sales), exp_sales);
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_sales", int'(sales), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dispense", int'(dispense), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    push(D, 5); push(RD, 2);
    pulse(0, 0, 1, 0);
    chk("q_disp_lat", int'(dispense), 1);
    @(posedge clk);
    #1;
    chk("q_dime_lat", int'(ret_dime), 1);
    exp_sales = 1;
    wait_idle("quarter");

    push(D, 3);
    pulse(1, 0, 0, 0);
    chk("n3_cr1", int'(credit), 1);
    pulse(1, 0, 0, 0);
    chk("n3_cr2", int'(credit), 2);
    pulse(1, 0, 0, 0);
    exp_sales = 2;
    wait_idle("nickel3");

    push(D, 7); push(RD, 4); push(RD, 2);
    pulse(0, 1, 0, 0);
    chk("dq_cr2", int'(credit), 2);
    pulse(0, 0, 1, 0);
    chk("dq_cr7", int'(credit), 7);
    exp_sales = 3;
    wait_idle("dime_quarter");

    push(RD, 2);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    wait_idle("dime_cancel");

    push(RN, 1);
    pulse(1, 0, 0, 1);
    wait_idle("nickel_cancel");

    push(RJ, 0);
    pulse(1, 1, 0, 0);
    chk("multi_cr0", int'(credit), 0);
    wait_idle("multi_coin");

    push(D, 7); push(RD, 4); push(RD | RJ, 2);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    @(posedge clk);
    #1;
    pulse(0, 0, 1, 0);
    exp_sales = 4;
    wait_idle("payout_reject");

    chk("sat_sales", int'(sales2), 3);

    push(D, 7);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_dispense", int'(dispense), 0);
    chk("ar_ret_dime", int'(ret_dime), 0);
    chk("ar_ret_nickel", int'(ret_nickel), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_credit", int'(credit), 0);
    chk("ar_sales", int'(sales), 0);
    chk("ar_drain", q.size(), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_sales = 0;
    @(posedge clk);
    #1;

    push(D, 5); push(RD, 2);
    pulse(0, 0, 1, 0);
    exp_sales = 1;
    wait_idle("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
